// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types for the MIPS core. Holds the multiply/divide unit
// operation codes and its FSM state encoding.
//   MDU_OP_WIDTH : width of the mdu op field
//   mdu_op_e     : MDU operation codes (MADD/MADDU are only legal when the
//                  unit is built with MIPS_MDU_MADD_EN)
//   mdu_state_e  : MDU sequencer states
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int MDU_OP_WIDTH = 3;

   typedef enum logic [MDU_OP_WIDTH-1:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5,
      MDU_MADD  = 3'd6,
      MDU_MADDU = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mips_mdu_step.sv
// -----------------------------------------------------------------------------
// mips_mdu_step
// One combinational iteration of the multiply/divide engine, retiring
// STAGE_BITS bits. acc holds {upper, lower} halves:
//   multiply : {partial product, remaining multiplier}; adds operand times
//              the low STAGE_BITS multiplier bits, then shifts right.
//   divide   : {partial remainder, dividend/quotient}; restoring division,
//              shifting dividend bits in at the top and quotient bits in at
//              the bottom.
// Ports:
//   is_div   in   select divide (1) or multiply (0) iteration
//   acc_in   in   2*DATA_WIDTH working register
//   operand  in   multiplicand or divisor magnitude
//   acc_out  out  working register after this iteration
// -----------------------------------------------------------------------------
module mips_mdu_step #(
   parameter int DATA_WIDTH = 32,
   parameter int STAGE_BITS = 1
) (
   input  logic                    is_div,
   input  logic [2*DATA_WIDTH-1:0] acc_in,
   input  logic [DATA_WIDTH-1:0]   operand,
   output logic [2*DATA_WIDTH-1:0] acc_out
);

   localparam int W = DATA_WIDTH;
   localparam int S = STAGE_BITS;

   logic [W+S-1:0] mul_sum;
   logic [2*W-1:0] div_acc;
   logic [W:0]     trial;
   logic [W:0]     diff;

   // NOTE: every variable gets a default before the loop so no path leaves it
   // unassigned (no latch), and blocking assignments are used so each unrolled
   // divide bit sees the result of the previous one within the same cycle.
   always_comb begin
      mul_sum = {{S{1'b0}}, acc_in[2*W-1:W]}
              + ({{S{1'b0}}, operand} * {{W{1'b0}}, acc_in[S-1:0]});
      div_acc = acc_in;
      trial   = '0;
      diff    = '0;
      for (int i = 0; i < S; i++) begin
         trial = {div_acc[2*W-1:W], div_acc[W-1]};
         diff  = trial - {1'b0, operand};
         // Borrow out of the top bit means the trial subtraction failed.
         if (!diff[W]) div_acc = {diff[W-1:0], div_acc[W-2:0], 1'b1};
         else          div_acc = {trial[W-1:0], div_acc[W-2:0], 1'b0};
      end
      acc_out = is_div ? div_acc : {mul_sum, acc_in[W-1:S]};
   end

endmodule

// File: rtl/mips_mdu.sv
// -----------------------------------------------------------------------------
// mips_mdu
// Iterative multiply/divide unit owning the HI/LO registers. An accepted
// MULT/MULTU/DIV/DIVU runs N = DATA_WIDTH/STAGE_BITS CALC cycles followed by
// one FIX cycle that applies signs and writes HI/LO. MTHI/MTLO write at once.
// Optional: define MIPS_MDU_MADD_EN to enable MADD/MADDU ({hi,lo} += product).
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   request, accepted only while busy=0
//   op        in   mdu_op_e code, sampled with start
//   rs_val    in   operand A (multiplicand / dividend)
//   rt_val    in   operand B (multiplier / divisor)
//   abort     in   cancel the in-flight operation (no writeback)
//   busy      out  operation in progress
//   done      out  one-cycle pulse, HI/LO hold the new result
//   div_zero  out  sticky divide-by-zero flag, cleared by the next start
//   hi, lo    out  HI / LO registers
// -----------------------------------------------------------------------------
module mips_mdu
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STAGE_BITS = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [MDU_OP_WIDTH-1:0] op,
   input  logic [DATA_WIDTH-1:0]   rs_val,
   input  logic [DATA_WIDTH-1:0]   rt_val,
   input  logic                    abort,
   output logic                    busy,
   output logic                    done,
   output logic                    div_zero,
   output logic [DATA_WIDTH-1:0]   hi,
   output logic [DATA_WIDTH-1:0]   lo
);

   localparam int W     = DATA_WIDTH;
   localparam int N     = DATA_WIDTH / STAGE_BITS;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   if ((DATA_WIDTH % 2 != 0) || (DATA_WIDTH % STAGE_BITS != 0)) begin : g_param_check
      $error("mips_mdu: DATA_WIDTH must be even and a multiple of STAGE_BITS");
   end

   mdu_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [2*W-1:0]   acc;
   logic [2*W-1:0]   acc_next;
   logic [W-1:0]     operand_q;
   logic             is_div_q;
   logic             neg_q;     // product / quotient must be negated
   logic             neg_r;     // remainder must be negated
   logic             dz_q;      // divide by zero, acc low half holds raw rs_val
`ifdef MIPS_MDU_MADD_EN
   logic             madd_q;
   logic [2*W-1:0]   madd_sum;
`endif

   logic             op_legal;
   logic             op_signed;
   logic             op_is_div;
   logic             a_neg;
   logic             b_neg;
   logic [W-1:0]     a_mag;
   logic [W-1:0]     b_mag;
   logic [2*W-1:0]   prod;
   logic [W-1:0]     quot;
   logic [W-1:0]     rem;

   always_comb begin
      op_is_div = (op == MDU_DIV) || (op == MDU_DIVU);
`ifdef MIPS_MDU_MADD_EN
      op_legal  = 1'b1;
      op_signed = (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD);
`else
      op_legal  = (op != MDU_MADD) && (op != MDU_MADDU);
      op_signed = (op == MDU_MULT) || (op == MDU_DIV);
`endif
      a_neg = op_signed & rs_val[W-1];
      b_neg = op_signed & rt_val[W-1];
      // The most-negative value maps onto its own unsigned magnitude.
      a_mag = a_neg ? -rs_val : rs_val;
      b_mag = b_neg ? -rt_val : rt_val;
   end

   always_comb begin
      prod = neg_q ? -acc : acc;
      quot = neg_q ? -acc[W-1:0] : acc[W-1:0];
      rem  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
   end

`ifdef MIPS_MDU_MADD_EN
   assign madd_sum = {hi, lo} + prod;
`endif

   mips_mdu_step #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGE_BITS (STAGE_BITS)
   ) u_step (
      .is_div  (is_div_q),
      .acc_in  (acc),
      .operand (operand_q),
      .acc_out (acc_next)
   );

   assign busy = (state != IDLE);

   // NOTE: the working registers are reset along with the architectural
   // state; they are few and this keeps the unit free of X after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         operand_q <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         dz_q      <= 1'b0;
`ifdef MIPS_MDU_MADD_EN
         madd_q    <= 1'b0;
`endif
         done      <= 1'b0;
         div_zero  <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort && op_legal) begin
                  div_zero <= 1'b0;
                  if (op == MDU_MTHI) begin
                     hi   <= rs_val;
                     done <= 1'b1;
                  end else if (op == MDU_MTLO) begin
                     lo   <= rs_val;
                     done <= 1'b1;
                  end else begin
                     cnt      <= '0;
                     is_div_q <= op_is_div;
                     neg_q    <= a_neg ^ b_neg;
                     neg_r    <= op_is_div & a_neg;
`ifdef MIPS_MDU_MADD_EN
                     madd_q   <= (op == MDU_MADD) || (op == MDU_MADDU);
`endif
                     if (op_is_div && (rt_val == '0)) begin
                        dz_q      <= 1'b1;
                        operand_q <= '0;
                        acc       <= {{W{1'b0}}, rs_val};
                        state     <= FIX;
                     end else if (op_is_div) begin
                        dz_q      <= 1'b0;
                        operand_q <= b_mag;
                        acc       <= {{W{1'b0}}, a_mag};
                        state     <= CALC;
                     end else begin
                        dz_q      <= 1'b0;
                        operand_q <= a_mag;
                        acc       <= {{W{1'b0}}, b_mag};
                        state     <= CALC;
                     end
                  end
               end
            end
            CALC: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(N - 1)) state <= FIX;
               end
            end
            FIX: begin
               state <= IDLE;
               if (!abort) begin
                  done <= 1'b1;
                  if (dz_q) begin
                     hi       <= acc[W-1:0];
                     lo       <= '1;
                     div_zero <= 1'b1;
                  end else if (is_div_q) begin
                     hi <= rem;
                     lo <= quot;
`ifdef MIPS_MDU_MADD_EN
                  end else if (madd_q) begin
                     {hi, lo} <= madd_sum;
`endif
                  end else begin
                     {hi, lo} <= prod;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
